// File: rtl/router_fifo_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : router_fifo_buf                                                 |
// | Purpose  : Per-destination packet buffer of the 1x3 router. It stores      |
// |            tagged bytes and plays packets back, zeroing dout after parity. |
// | Options  : ROUTER_FIFO_OVF_EN adds a sticky overflow flag output (ovf).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module router_fifo_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          soft_reset,
    input  logic          write_enb,
    input  logic          read_enb,
    input  logic          lfd_state,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
`ifdef ROUTER_FIFO_OVF_EN
    ,
    output logic          ovf
`endif
);

    localparam int           CW        = 7;
    localparam logic [AW:0]  c_PTR_ONE = (AW+1)'(1);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

    logic [DW:0]     r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_dout;

    logic            w_full;
    logic            w_empty;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [DW:0]     w_rd_entry;

    // The wrap bit separates a full buffer from an empty one with equal low bits.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_acc   = write_enb && !w_full;
    assign w_rd_acc   = read_enb && !w_empty;
    assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_acc && !soft_reset) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, din};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (soft_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // A header reload counts payload bytes plus the trailing parity byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (soft_reset) begin
            r_cnt <= '0;
        end else if (w_rd_acc) begin
            if (w_rd_entry[DW]) begin
                r_cnt <= CW'(w_rd_entry[DW-1:2]) + c_CNT_ONE;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout <= '0;
        end else if (soft_reset) begin
            r_dout <= '0;
        end else if (w_rd_acc) begin
            r_dout <= w_rd_entry[DW-1:0];
        end else if (r_cnt == '0) begin
            r_dout <= '0;
        end
    end

    assign dout  = r_dout;
    assign full  = w_full;
    assign empty = w_empty;

`ifdef ROUTER_FIFO_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (soft_reset) begin
            r_ovf <= 1'b0;
        end else if (write_enb && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_fifo_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_router_fifo_buf                                              |
// | Purpose  : Directed plus random stimulus against a queue-based model.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_router_fifo_buf;

    logic       clk;
    logic       rstn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
`ifdef ROUTER_FIFO_OVF_EN
    logic       ovf;
`endif

    router_fifo_buf #(.DEPTH(16), .AW(4), .DW(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .din        (din),
        .dout       (dout),
        .full       (full),
        .empty      (empty)
`ifdef ROUTER_FIFO_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;

    logic [8:0]  q[$];
    logic [7:0]  m_dout;
    int          m_cnt;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout"},  {24'd0, dout}, {24'd0, m_dout});
        chk({tag, ".full"},  {31'd0, full}, (q.size() == 16) ? 32'd1 : 32'd0);
        chk({tag, ".empty"}, {31'd0, empty}, (q.size() == 0) ? 32'd1 : 32'd0);
        chk({tag, ".cnt"},   {25'd0, dut.r_cnt}, m_cnt);
`ifdef ROUTER_FIFO_OVF_EN
        chk({tag, ".ovf"},   {31'd0, ovf}, {31'd0, m_ovf});
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 8'h00;
        m_cnt  = 0;
        m_ovf  = 1'b0;
    endtask

    // One clock: drive inputs, advance the model on the edge, compare just after.
    task automatic cyc(input string tag, input logic we, input logic re,
                       input logic lfd, input logic [7:0] d, input logic sr);
        bit         was_full;
        bit         was_empty;
        logic [8:0] e;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        din        = d;
        soft_reset = sr;
        @(posedge clk);
        was_full  = (q.size() == 16);
        was_empty = (q.size() == 0);
        if (sr) begin
            model_reset();
        end else begin
            if (we && was_full) m_ovf = 1'b1;
            if (re && !was_empty) begin
                e      = q.pop_front();
                m_dout = e[7:0];
                if (e[8])           m_cnt = int'(e[7:2]) + 1;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end else if (m_cnt == 0) begin
                m_dout = 8'h00;
            end
            if (we && !was_full) q.push_back({lfd, d});
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        logic [7:0] saved[16];
        logic [7:0] pkt[5];
        rstn       = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        din        = 8'h00;
        model_reset();
        #2;
        chk("reset.dout",  {24'd0, dout}, 32'd0);
        chk("reset.full",  {31'd0, full}, 32'd0);
        chk("reset.empty", {31'd0, empty}, 32'd1);
        #10 rstn = 1'b1;

        // Header 0x0C announces three payload bytes plus parity.
        pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h00;
        for (int i = 0; i < 5; i++) cyc("pkt_wr", 1'b1, 1'b0, (i == 0), pkt[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc("pkt_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("pkt_rd.const", {24'd0, dout}, {24'd0, pkt[i]});
            chk("pkt_cnt.const", {25'd0, dut.r_cnt}, 32'(4 - i));
        end
        cyc("pkt_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("pkt_idle.const", {24'd0, dout}, 32'd0);
        chk("pkt_empty.const", {31'd0, empty}, 32'd1);

        // Fill, drop an overflowing write, then drain in order.
        for (int i = 0; i < 16; i++) begin
            saved[i] = 8'($urandom);
            cyc("fill", 1'b1, 1'b0, 1'b0, saved[i], 1'b0);
        end
        chk("fill.full.const", {31'd0, full}, 32'd1);
        cyc("drop", 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cyc("drain", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("drain.const", {24'd0, dout}, {24'd0, saved[i]});
        end
        chk("drain.empty.const", {31'd0, empty}, 32'd1);

        // Simultaneous requests at full and at empty.
        for (int i = 0; i < 16; i++) cyc("fill2", 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        cyc("both_full", 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
        chk("both_full.full.const", {31'd0, full}, 32'd0);
        for (int i = 0; i < 15; i++) cyc("drain2", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc("both_empty", 1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
        chk("both_empty.empty.const", {31'd0, empty}, 32'd0);
        cyc("drain3", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Pointer wrap with steady occupancy.
        for (int i = 0; i < 3; i++) cyc("wrap_pre", 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) cyc("wrap", 1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) cyc("wrap_post", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Soft reset during a read, then a fresh packet.
        for (int i = 0; i < 6; i++) cyc("sr_load", 1'b1, 1'b0, (i == 0), 8'($urandom), 1'b0);
        cyc("sr_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc("sr", 1'b1, 1'b1, 1'b0, 8'hEE, 1'b1);
        chk("sr.empty.const", {31'd0, empty}, 32'd1);
        chk("sr.dout.const", {24'd0, dout}, 32'd0);
        pkt[0] = 8'h08; pkt[1] = 8'hA1; pkt[2] = 8'hB2; pkt[3] = 8'h13;
        for (int i = 0; i < 4; i++) cyc("sr_pkt_wr", 1'b1, 1'b0, (i == 0), pkt[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc("sr_pkt_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("sr_pkt_rd.const", {24'd0, dout}, {24'd0, pkt[i]});
        end
        cyc("sr_pkt_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Randomized traffic with occasional header tags.
        for (int i = 0; i < 300; i++) begin
            cyc("rand", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 7) == 0), 8'($urandom), 1'b0);
        end

        // Asynchronous reset in the middle of a packet.
        cyc("ar_wr", 1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
        cyc("ar_wr", 1'b1, 1'b1, 1'b0, 8'h42, 1'b0);
        cyc("ar_wr", 1'b1, 1'b1, 1'b0, 8'h43, 1'b0);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("async.dout",  {24'd0, dout}, 32'd0);
        chk("async.empty", {31'd0, empty}, 32'd1);
        chk("async.full",  {31'd0, full}, 32'd0);
        model_reset();
        #1 rstn = 1'b1;
        cyc("post_ar", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

`ifdef ROUTER_FIFO_OVF_EN
        for (int i = 0; i < 16; i++) cyc("ovf_fill", 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0);
        cyc("ovf_set", 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
        chk("ovf_set.const", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < 3; i++) cyc("ovf_hold", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc("ovf_clr", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_clr.const", {31'd0, ovf}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
